ntt_sched: RTL and testbench
============================

Name: ntt_sched

Overview:
- Round-robin scheduler sharing one streaming ntt core between N_REQ requesters.
- Grants one job at a time and latches that job's algo/intt mode for the core.
- Forwards the granted requester's 256-coefficient input stream to the core, then routes the core's 256-coefficient output stream back to the owner.
- Sits between polynomial-arithmetic clients (sign/verify datapaths) and the single ntt instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 32, coefficient width (signed).
- N_COEF, 256, coefficients per transform.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  N_REQ  per-requester job request (level)
- i_algo  in  N_REQ  per-requester algo select, sampled at grant
- i_intt  in  N_REQ  per-requester inverse select, sampled at grant
- i_valid  in  N_REQ  per-requester input-coefficient valid
- i_data  in  N_REQ*DATA_W  per-requester coefficient; slice k belongs to requester k
- o_gnt  out  N_REQ  one-hot grant, held from LOAD until DONE
- o_valid  out  N_REQ  one-hot output-coefficient valid
- o_data  out  DATA_W  output coefficient, shared by all requesters
- o_done  out  N_REQ  one-cycle completion pulse
- o_busy  out  1  high in any state except IDLE
- o_err  out  1  watchdog error pulse (always 0 without the optional feature)
- o_core_ready  out  1  to core i_ready
- o_core_algo  out  1  to core i_algo
- o_core_intt  out  1  to core i_intt
- o_core_data  out  DATA_W  to core i_data
- i_core_valid  in  1  from core o_valid
- i_core_data  in  DATA_W  from core o_data

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, counters 0.
- States:
  - IDLE -> LOAD: when any i_req is high. Winner is the first requester at or after the rr pointer. o_gnt, algo and intt are registered that same edge. rr pointer becomes winner+1 mod N_REQ.
  - LOAD: o_core_ready is registered i_valid[gnt]; o_core_data is registered i_data[gnt] (1-cycle latency). Gaps in i_valid are allowed: core ready drops for those cycles. in_cnt counts accepted coefficients; after the N_COEF-th accept -> WAIT. Requester valids while not granted are ignored.
  - WAIT -> DRAIN: on the first i_core_valid.
  - DRAIN (that first beat is also handled here): every i_core_valid produces o_valid[gnt]=1 and o_data=i_core_data on the next cycle. out_cnt counts beats; after the N_COEF-th beat -> DONE.
  - DONE: o_done[gnt]=1 for one cycle, o_gnt cleared, -> IDLE. A new grant is possible on the following cycle.
- i_core_valid while in IDLE or LOAD is ignored: no o_valid is produced.
- o_core_algo/o_core_intt hold their latched values from grant until the next grant.
- Dropping i_req after grant does not abort the job; the job completes normally.
- Asserting reset mid-job returns to IDLE immediately and all outputs go to 0. The core shares the same reset (active-low at this level; the core's active-high reset is driven inverted).
- Counters are $clog2(N_COEF)+1 bits wide; no wrap occurs within a job.

Optional Feature:
- Macro: NTT_SCHED_TIMEOUT_EN.
- Defined: a watchdog counter runs in WAIT and DRAIN and clears on each i_core_valid. On reaching TIMEOUT_CYC: o_err pulses one cycle, o_done is not asserted, o_gnt clears, state -> IDLE.
- Not defined: no watchdog logic; o_err is tied to 0; WAIT and DRAIN wait indefinitely.

Decomposition:
- Package ntt_sched_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, DRAIN, DONE);
  - N_COEF_DEF = 256;
  - the coefficient typedef (logic signed [31:0]).
- One sub-module, rr_arbiter: N_REQ-wide round-robin pick. Inputs are the request vector and the pointer; output is a one-hot winner. It is purely combinational; the pointer register stays in ntt_sched.

Test Plan:
- Single job, req0 only, algo=1, intt=0, inputs i%3329 contiguous, with a core model of fixed 300-cycle latency -> o_gnt=01 for the whole job, exactly 256 o_valid[0] beats matching the model, o_done[0] pulses once, o_busy drops the cycle after.
- req0 and req1 asserted together and held for 3 jobs -> grant order 0,1,0; o_core_intt follows each owner's i_intt.
- i_valid[0] low for 5 cycles at coefficient 100 -> o_core_ready shows a 5-cycle gap; the core still receives exactly 256 coefficients in order; the transform completes.
- Stray i_core_valid during LOAD -> no o_valid; out_cnt unchanged.
- Reset asserted at DRAIN beat 128 -> all outputs 0 immediately; a fresh req1 job afterwards completes with 256 beats.
- With NTT_SCHED_TIMEOUT_EN and TIMEOUT_CYC=50, core stalls after beat 10 -> o_err pulses 50 cycles after beat 10, no o_done, state IDLE. Without the macro -> o_busy stays high.

Source files
------------

// File: rtl/ntt_sched_pkg.sv
// Shared types and defaults for the ntt job scheduler.
package ntt_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam int N_COEF_DEF = 256;

    typedef logic signed [31:0] coef_t;

endpackage

// File: rtl/ntt_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import ntt_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntt_sched.sv
// Round-robin scheduler sharing one streaming ntt core between N_REQ requesters.
// Optional watchdog on the core output stream: define NTT_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job, waiting for any request
// LOAD  | forwarding the owner's coefficients to the core
// WAIT  | all inputs sent, waiting for the first core output
// DRAIN | routing core outputs back to the owner
// DONE  | one-cycle completion, grant released
module ntt_sched
    import ntt_sched_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 32,
    parameter int N_COEF      = N_COEF_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_algo,
    input  logic [N_REQ-1:0]        i_intt,
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic [N_REQ-1:0]        o_done,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_core_ready,
    output logic                    o_core_algo,
    output logic                    o_core_intt,
    output logic [DATA_W-1:0]       o_core_data,
    input  logic                    i_core_valid,
    input  logic [DATA_W-1:0]       i_core_data
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(N_COEF) + 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("ntt_sched: unsupported parameter set");
    end

    state_t              state, state_nxt;
    logic [N_REQ-1:0]    win;
    logic [PTR_W-1:0]    win_idx;
    logic [N_REQ-1:0]    gnt_q, gnt_nxt;
    logic [PTR_W-1:0]    gidx_q, gidx_nxt, ptr_q, ptr_nxt;
    logic                algo_q, algo_nxt, intt_q, intt_nxt;
    logic                ready_q, ready_nxt;
    logic [DATA_W-1:0]   cdata_q, cdata_nxt, odata_q, odata_nxt;
    logic [CNT_W-1:0]    in_cnt, in_nxt, out_cnt, out_nxt;
    logic [N_REQ-1:0]    valid_q, valid_nxt, done_q, done_nxt;

`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q, wd_nxt;
    logic                err_q, err_nxt;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (win)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++)
            if (win[k]) win_idx = PTR_W'(k);
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        gidx_nxt  = gidx_q;
        ptr_nxt   = ptr_q;
        algo_nxt  = algo_q;
        intt_nxt  = intt_q;
        ready_nxt = 1'b0;
        cdata_nxt = cdata_q;
        odata_nxt = odata_q;
        in_nxt    = in_cnt;
        out_nxt   = out_cnt;
        valid_nxt = '0;
        done_nxt  = '0;
`ifdef NTT_SCHED_TIMEOUT_EN
        wd_nxt    = wd_q;
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|i_req) begin
                    state_nxt = LOAD;
                    gnt_nxt   = win;
                    gidx_nxt  = win_idx;
                    algo_nxt  = i_algo[win_idx];
                    intt_nxt  = i_intt[win_idx];
                    ptr_nxt   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    in_nxt    = '0;
                    out_nxt   = '0;
`ifdef NTT_SCHED_TIMEOUT_EN
                    wd_nxt    = '0;
`endif
                end
            end
            LOAD: begin
                ready_nxt = i_valid[gidx_q];
                cdata_nxt = i_data[int'(gidx_q)*DATA_W +: DATA_W];
                if (i_valid[gidx_q]) begin
                    in_nxt = in_cnt + 1'b1;
                    if (in_cnt == CNT_W'(N_COEF - 1)) state_nxt = WAIT;
                end
            end
            // the first core beat is taken in WAIT exactly like a DRAIN beat
            WAIT, DRAIN: begin
                if (i_core_valid) begin
                    valid_nxt = gnt_q;
                    odata_nxt = i_core_data;
                    out_nxt   = out_cnt + 1'b1;
                    if (out_cnt == CNT_W'(N_COEF - 1)) begin
                        state_nxt = DONE;
                        done_nxt  = gnt_q;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
`ifdef NTT_SCHED_TIMEOUT_EN
                if (i_core_valid) begin
                    wd_nxt = '0;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_nxt   = 1'b1;
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    wd_nxt = wd_q + 1'b1;
                end
`endif
            end
            DONE: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            algo_q  <= 1'b0;
            intt_q  <= 1'b0;
            ready_q <= 1'b0;
            cdata_q <= '0;
            odata_q <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            valid_q <= '0;
            done_q  <= '0;
`ifdef NTT_SCHED_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            gidx_q  <= gidx_nxt;
            ptr_q   <= ptr_nxt;
            algo_q  <= algo_nxt;
            intt_q  <= intt_nxt;
            ready_q <= ready_nxt;
            cdata_q <= cdata_nxt;
            odata_q <= odata_nxt;
            in_cnt  <= in_nxt;
            out_cnt <= out_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
`ifdef NTT_SCHED_TIMEOUT_EN
            wd_q    <= wd_nxt;
            err_q   <= err_nxt;
`endif
        end
    end

    assign o_gnt        = gnt_q;
    assign o_valid      = valid_q;
    assign o_data       = odata_q;
    assign o_done       = done_q;
    assign o_busy       = (state != IDLE);
    assign o_core_ready = ready_q;
    assign o_core_algo  = algo_q;
    assign o_core_intt  = intt_q;
    assign o_core_data  = cdata_q;
`ifdef NTT_SCHED_TIMEOUT_EN
    assign o_err        = err_q;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: behavioural core model, round-robin reference and output scoreboard.
// Build with NTT_SCHED_TIMEOUT_EN to exercise the watchdog with a 50-cycle limit.
module tb_ntt_sched;
    import ntt_sched_pkg::*;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int N_COEF = N_COEF_DEF;
`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
    localparam int LAT_MAIN    = 30;
`else
    localparam int TIMEOUT_CYC = 4096;
    localparam int LAT_MAIN    = 300;
`endif

    logic                    i_clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic [N_REQ-1:0]        i_req = '0, i_algo = '0, i_intt = '0, i_valid = '0;
    logic [N_REQ*DATA_W-1:0] i_data = '0;
    logic [N_REQ-1:0]        o_gnt, o_valid, o_done;
    logic [DATA_W-1:0]       o_data, o_core_data;
    logic                    o_busy, o_err, o_core_ready, o_core_algo, o_core_intt;
    logic                    i_core_valid = 1'b0;
    logic [DATA_W-1:0]       i_core_data = '0;

    ntt_sched #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .N_COEF(N_COEF), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_algo(i_algo), .i_intt(i_intt),
        .i_valid(i_valid), .i_data(i_data), .o_gnt(o_gnt), .o_valid(o_valid), .o_data(o_data),
        .o_done(o_done), .o_busy(o_busy), .o_err(o_err), .o_core_ready(o_core_ready),
        .o_core_algo(o_core_algo), .o_core_intt(o_core_intt), .o_core_data(o_core_data),
        .i_core_valid(i_core_valid), .i_core_data(i_core_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0, n_pass = 0;
    coef_t sent [N_COEF];
    coef_t cbuf [N_COEF];
    logic [DATA_W-1:0] obs_q [$];
    int done_cnt = 0, err_cnt = 0, vbad = 0, inv_bad = 0;
    int mdl_ptr = 0;
    bit cfg_algo [N_REQ];
    bit cfg_intt [N_REQ];
    int core_lat = LAT_MAIN, stall_at = -1;
    bit stray_pending = 1'b0;
    int phase = 0, cin = 0, lcnt = 0, eidx = 0;
    bit c_a, c_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    // stand-in transform applied by the core model, so mode forwarding is visible in the data
    function automatic logic [31:0] xform(input logic [31:0] x, input bit a, input bit inv);
        logic [31:0] r;
        r = x * 32'd5 + (a ? 32'd17 : 32'd0);
        if (inv) r = ~r;
        return r;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] req, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (req[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    // core model: collect N_COEF inputs, wait core_lat cycles, stream N_COEF results
    initial begin
        forever begin
            @(negedge i_clk);
            i_core_valid = 1'b0;
            if (!i_rst_n) begin
                phase = 0; cin = 0; eidx = 0;
            end else begin
                case (phase)
                    0: begin
                        if (o_core_ready) begin
                            cbuf[cin] = o_core_data;
                            cin++;
                            if (cin == N_COEF) begin
                                phase = 1; lcnt = core_lat; c_a = o_core_algo; c_i = o_core_intt;
                            end
                        end
                        if (stray_pending && cin > 0) begin
                            i_core_valid  = 1'b1;
                            i_core_data   = 32'hDEAD_BEEF;
                            stray_pending = 1'b0;
                        end
                    end
                    1: begin
                        lcnt--;
                        if (lcnt <= 0) begin phase = 2; eidx = 0; end
                    end
                    default: begin
                        if (!(stall_at >= 0 && eidx >= stall_at)) begin
                            i_core_valid = 1'b1;
                            i_core_data  = xform(cbuf[eidx], c_a, c_i);
                            eidx++;
                            if (eidx == N_COEF) begin phase = 0; cin = 0; end
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_valid != '0) begin
                obs_q.push_back(o_data);
                if (o_valid != o_gnt) vbad++;
            end
            if (o_done != '0) done_cnt++;
            if (o_err) err_cnt++;
            if (o_busy != (o_gnt != '0)) inv_bad++;
        end
    end

    task automatic drive(input int own, input bit on, input logic [31:0] val);
        for (int k = 0; k < N_REQ; k++) begin
            if (k == own) begin
                i_valid[k] = on;
                i_data[k*DATA_W +: DATA_W] = val;
            end else begin
                i_valid[k] = i_req[k];
                i_data[k*DATA_W +: DATA_W] = $urandom;
            end
        end
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < N_REQ; k++) begin
            i_algo[k] = cfg_algo[k];
            i_intt[k] = cfg_intt[k];
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req = '0; i_valid = '0; stray_pending = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        mdl_ptr = 0;
        tick();
    endtask

    task automatic start_job(input int pat, input int gap_at, input int gap_len,
                             input bit stray, input bit hold_req, output int own);
        int t, lowc, highc, exp_own;
        exp_own = rr_pick(i_req, mdl_ptr);
        obs_q.delete();
        done_cnt = 0;
        t = 0;
        while (o_gnt == '0 && t < 20) begin tick(); t++; end
        chk("grant", o_gnt, (exp_own < 0) ? 0 : (1 << exp_own));
        own = (exp_own < 0) ? 0 : exp_own;
        mdl_ptr = (own + 1) % N_REQ;
        if (!hold_req) i_req = '0;
        chk("core_algo", o_core_algo, cfg_algo[own]);
        chk("core_intt", o_core_intt, cfg_intt[own]);
        lowc = 0; highc = 0;
        for (int c = 0; c < N_COEF; c++) begin
            sent[c] = (pat == 0) ? coef_t'(c % 3329) : coef_t'($urandom);
            if (c == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(own, 1'b0, 32'h0);
                    tick();
                    if (!o_core_ready) lowc++;
                end
            end
            drive(own, 1'b1, sent[c]);
            if (stray && c == 20) stray_pending = 1'b1;
            tick();
            if (o_core_ready) highc++;
        end
        i_valid = '0;
        chk("ready_beats", highc, N_COEF);
        if (gap_len > 0) chk("ready_gap", lowc, gap_len);
    endtask

    task automatic finish_job(input int own, input bit drop_req);
        int t, bad;
        t = 0;
        while (o_done == '0 && t < 4000) begin tick(); t++; end
        chk("done", o_done, 1 << own);
        if (drop_req) i_req = '0;
        tick();
        chk("busy_drop", o_busy, 0);
        chk("mode_hold", {o_core_algo, o_core_intt}, {cfg_algo[own], cfg_intt[own]});
        chk("done_cnt", done_cnt, 1);
        chk("beats", obs_q.size(), N_COEF);
        bad = 0;
        for (int i = 0; i < obs_q.size() && i < N_COEF; i++)
            if (obs_q[i] !== xform(sent[i], cfg_algo[own], cfg_intt[own])) bad++;
        chk("data_err", bad, 0);
    endtask

    initial begin
        int own, t;
        repeat (3) tick();
        chk("rst_ctl", {o_gnt, o_valid, o_done, o_busy, o_err, o_core_ready, o_core_algo, o_core_intt}, 0);
        chk("rst_data", {o_data, o_core_data}, 0);
        i_rst_n = 1'b1;
        tick();

        // single job, requester 0, algo=1 intt=0, contiguous i%3329
        cfg_algo[0] = 1'b1; cfg_intt[0] = 1'b0; cfg_algo[1] = 1'b0; cfg_intt[1] = 1'b1;
        apply_cfg();
        core_lat = LAT_MAIN;
        i_req = 2'b01;
        start_job(0, -1, 0, 1'b0, 1'b0, own);
        finish_job(own, 1'b0);

        // both requesters held for three jobs
        do_reset();
        core_lat = 25;
        cfg_algo[0] = 1'($urandom); cfg_algo[1] = 1'($urandom);
        cfg_intt[0] = 1'b0; cfg_intt[1] = 1'b1;
        apply_cfg();
        i_req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            start_job(1, -1, 0, 1'b0, 1'b1, own);
            chk("rr_order", own, (j % 2 == 0) ? 0 : 1);
            finish_job(own, j == 2);
        end

        // 5-cycle input gap at coefficient 100
        cfg_intt[0] = 1'($urandom);
        apply_cfg();
        i_req = 2'b01;
        start_job(1, 100, 5, 1'b0, 1'b0, own);
        finish_job(own, 1'b0);

        // stray core valid while loading
        i_req = 2'b10;
        start_job(1, -1, 0, 1'b1, 1'b0, own);
        finish_job(own, 1'b0);

        // reset in the middle of the drain, then a fresh requester-1 job
        i_req = 2'b01;
        start_job(1, -1, 0, 1'b0, 1'b0, own);
        t = 0;
        while (obs_q.size() < 128 && t < 2000) begin tick(); t++; end
        chk("drain_128", obs_q.size(), 128);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {o_gnt, o_valid, o_done, o_busy, o_err, o_core_ready, o_core_algo, o_core_intt}, 0);
        chk("midrst_data", {o_data, o_core_data}, 0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        mdl_ptr = 0;
        tick();
        i_req = 2'b10;
        start_job(1, -1, 0, 1'b0, 1'b0, own);
        finish_job(own, 1'b0);

        // core stalls after 10 output beats
        stall_at = 10;
        i_req = 2'b01;
        start_job(1, -1, 0, 1'b0, 1'b0, own);
        t = 0;
        while (obs_q.size() < 10 && t < 2000) begin tick(); t++; end
        chk("stall_beats", obs_q.size(), 10);
`ifdef NTT_SCHED_TIMEOUT_EN
        t = 0;
        while (!o_err && t < 200) begin tick(); t++; end
        chk("wd_delay", t, TIMEOUT_CYC);
        chk("wd_idle", {o_busy, o_gnt}, 0);
        chk("wd_no_done", done_cnt, 0);
        tick();
        chk("wd_pulse", o_err, 0);
        chk("wd_err_cnt", err_cnt, 1);
`else
        repeat (200) tick();
        chk("stall_busy", o_busy, 1);
        chk("stall_no_err", err_cnt, 0);
        chk("stall_no_done", done_cnt, 0);
`endif
        stall_at = -1;
        do_reset();

        chk("valid_owner", vbad, 0);
        chk("busy_gnt", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
